// File: rtl/duty_pkg.sv
// Purpose: shared FSM state encoding and result width for the duty-cycle scanner.
// Latency: none (types and constants only).
// Backpressure: none.
package duty_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_PRESENT = 2'd3
  } state_t;

  // Width of the presented high-cycle count (window count is zero-extended into it).
  localparam int RES_W = 16;

endpackage

// File: rtl/duty_window_meter.sv
// Purpose: counts high cycles of an already-synchronized bit over a 2^WIN_LOG2-cycle window.
// Latency: window runs the 2^WIN_LOG2 cycles after i_start; o_done/o_count valid in the last one.
// Backpressure: none; the caller must consume o_count in the o_done cycle.
module duty_window_meter
  import duty_pkg::*;
#(
  parameter int WIN_LOG2 = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_bit,
  output logic                o_done,
  output logic [WIN_LOG2:0]   o_count
);

  logic                r_run;
  logic [WIN_LOG2-1:0] r_win;
  logic [WIN_LOG2:0]   r_high;

  // o_count includes the current cycle's bit so the final window cycle is counted
  // without an extra pipeline stage; WIN_LOG2+1 bits holds the full 2^WIN_LOG2.
  assign o_done  = r_run && (r_win == '1);
  assign o_count = r_high + {{WIN_LOG2{1'b0}}, i_bit};

  // Window position and running high count; a start pulse restarts both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run  <= 1'b0;
      r_win  <= '0;
      r_high <= '0;
    end else if (i_start) begin
      r_run  <= 1'b1;
      r_win  <= '0;
      r_high <= '0;
    end else if (r_run) begin
      r_win  <= r_win + WIN_LOG2'(1);
      r_high <= o_count;
      if (o_done) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/duty_scan_controller.sv
// Purpose: scans masked ring-oscillator channels in ascending order, one duty measurement each;
//          DUTY_SCAN_AUTORESTART_EN makes the scan loop over the latched mask until reset.
// Latency: per channel SETTLE settle cycles + 2^WIN_LOG2 measure cycles, then result held in PRESENT.
// Backpressure: res_valid/res_ready; result held stable until accepted, scan stalls meanwhile.
module duty_scan_controller
  import duty_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WIN_LOG2 = 8,
  parameter int SETTLE   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_CH-1:0]         ch_mask,
  input  logic [NUM_CH-1:0]         ring_in,
  output logic                      busy,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(NUM_CH)-1:0] res_ch,
  output logic [RES_W-1:0]          res_value,
  output logic                      done
);

  localparam int         CH_W        = $clog2(NUM_CH);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t              r_state, w_state_nxt;
  logic [NUM_CH-1:0]   r_sync1, r_sync2, r_mask, w_above;
  logic [CH_W-1:0]     r_ch, r_res_ch, w_first_in, w_first_mask, w_next_ch;
  logic [7:0]          r_settle;
  logic [RES_W-1:0]    r_res_value;
  logic [WIN_LOG2:0]   w_meter_count;
  logic                r_done, w_done_nxt, w_next_vld, w_sel_bit;
  logic                w_meter_start, w_meter_done, w_load, w_xfer;

  // Index of the lowest set bit; callers only use it when the vector is non-zero.
  function automatic logic [CH_W-1:0] f_lowest(input logic [NUM_CH-1:0] m);
    f_lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) f_lowest = CH_W'(i);
    end
  endfunction

  // Two-flop synchronizer on every ring input; only synchronized bits reach the mux.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ring_in;
      r_sync2 <= r_sync1;
    end
  end

  // Latched-mask channels strictly above the current one, for the next-channel search.
  always_comb begin
    w_above = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_above[i] = r_mask[i] && (i > int'(r_ch));
    end
  end

  assign w_first_in   = f_lowest(ch_mask);
  assign w_first_mask = f_lowest(r_mask);
  assign w_next_ch    = f_lowest(w_above);
  assign w_next_vld   = |w_above;
  assign w_sel_bit    = r_sync2[r_ch];
  assign w_load       = (r_state == ST_IDLE) && start && (ch_mask != '0);
  assign w_xfer       = (r_state == ST_PRESENT) && res_ready;

  duty_window_meter #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_meter (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_meter_start),
    .i_bit   (w_sel_bit),
    .o_done  (w_meter_done),
    .o_count (w_meter_count)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode plus meter start and end-of-scan pulse request.
  always_comb begin
    w_state_nxt   = r_state;
    w_meter_start = 1'b0;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (ch_mask != '0) w_state_nxt = ST_SETTLE;
          else               w_done_nxt  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (r_settle == SETTLE_LAST) begin
          w_state_nxt   = ST_MEASURE;
          w_meter_start = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (w_meter_done) w_state_nxt = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (res_ready) begin
          if (w_next_vld) begin
            w_state_nxt = ST_SETTLE;
          end else begin
            w_done_nxt = 1'b1;
`ifdef DUTY_SCAN_AUTORESTART_EN
            w_state_nxt = ST_SETTLE;
`else
            w_state_nxt = ST_IDLE;
`endif
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Scan bookkeeping: latched mask, current channel, settle counter, result capture, done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask      <= '0;
      r_ch        <= '0;
      r_settle    <= '0;
      r_res_ch    <= '0;
      r_res_value <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_load) begin
        r_mask <= ch_mask;
        r_ch   <= w_first_in;
      end else if (w_xfer) begin
        // Wrapping to the lowest channel only matters when the scan restarts.
        r_ch <= w_next_vld ? w_next_ch : w_first_mask;
      end
      if ((r_state == ST_SETTLE) && (r_settle != SETTLE_LAST)) r_settle <= r_settle + 8'd1;
      else                                                     r_settle <= 8'd0;
      if ((r_state == ST_MEASURE) && w_meter_done) begin
        r_res_ch    <= r_ch;
        r_res_value <= RES_W'(w_meter_count);
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign res_valid = (r_state == ST_PRESENT);
  assign res_ch    = r_res_ch;
  assign res_value = r_res_value;
  assign done      = r_done;

endmodule

// File: doc/duty_scan_controller.md
DUTY_SCAN_CONTROLLER -- requirements
Module: duty_scan_controller

Interface
REQ-001 Parameter NUM_CH, default 4: number of ring-oscillator channels, range 2..16.
REQ-002 Parameter WIN_LOG2, default 8: measurement window is 2^WIN_LOG2 clk cycles, range 4..15.
REQ-003 Parameter SETTLE, default 4: idle cycles after a channel switch before counting, range 2..255.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  request a scan; sampled only in IDLE.
REQ-007 ch_mask  in  NUM_CH  channels to scan; latched with start.
REQ-008 ring_in  in  NUM_CH  asynchronous ring-oscillator outputs.
REQ-009 busy  out  1  high whenever state is not IDLE.
REQ-010 res_valid  out  1  result available.
REQ-011 res_ready  in  1  consumer accepts result.
REQ-012 res_ch  out  clog2(NUM_CH)  channel index of the presented result.
REQ-013 res_value  out  16  high-cycle count for the window, zero-extended.
REQ-014 done  out  1  one-cycle pulse at end of a scan.

Function
REQ-015 FSM states SHALL be IDLE, SETTLE, MEASURE, PRESENT.
REQ-016 IDLE: start=1 with ch_mask!=0 SHALL latch ch_mask, select lowest set bit, go SETTLE next cycle.
REQ-017 IDLE: start=1 with ch_mask==0 SHALL pulse done next cycle and stay IDLE.
REQ-018 start while busy SHALL be ignored; the latched mask SHALL not change mid-scan.
REQ-019 Each ring_in bit SHALL pass a 2-flop synchronizer before use; selection is a mux on synchronized bits.
REQ-020 SETTLE SHALL last exactly SETTLE cycles, then MEASURE.
REQ-021 MEASURE SHALL last exactly 2^WIN_LOG2 cycles; high count increments on each cycle the selected synchronized bit is 1.
REQ-022 High count SHALL be WIN_LOG2+1 bits; constant-high input yields exactly 2^WIN_LOG2, constant-low yields 0; no wrap.
REQ-023 After the last MEASURE cycle, state SHALL be PRESENT with res_valid=1, res_ch, res_value registered.
REQ-024 res_ch and res_value SHALL hold stable while res_valid=1 and res_ready=0.
REQ-025 Transfer occurs on res_valid&&res_ready; res_ready while res_valid=0 SHALL have no effect.
REQ-026 On transfer, next higher set bit of latched mask SHALL be selected and state SHALL go SETTLE; if none, done pulses that same next cycle and state goes IDLE.
REQ-027 res_valid SHALL deassert the cycle after transfer; results SHALL emerge in ascending channel order.

Reset
REQ-028 reset SHALL asynchronously force IDLE, busy=0, res_valid=0, done=0, res_ch=0, res_value=0, counters and latched mask to 0.
REQ-029 reset mid-scan SHALL discard any in-flight result; no done pulse SHALL follow.
REQ-030 Synchronizer flops SHALL reset to 0.

Configuration
REQ-031 Macro DUTY_SCAN_AUTORESTART_EN defined: at scan end done pulses and scan restarts at lowest set bit of latched mask (SETTLE), busy stays 1; only reset returns to IDLE.
REQ-032 Macro undefined: scan end returns to IDLE per REQ-026.

Structure
REQ-033 Shared package duty_pkg SHALL hold the FSM state enum and the 16-bit result width constant.
REQ-034 Sub-module duty_window_meter SHALL contain synchronized-input window and high counters with start/done interface; controller owns FSM, mux, handshake.

Verification
REQ-035 ch_mask=4'b0101, ring_in[0] const 1, ring_in[2] const 0, res_ready=1 -> results (ch0,256) then (ch2,0), done once, busy low after.
REQ-036 ring_in[1] square wave period 4 (2 high/2 low), mask=4'b0010 -> res_value in 127..129.
REQ-037 res_ready held 0 for 50 cycles in PRESENT -> res_valid, res_ch, res_value constant; state unchanged.
REQ-038 start with ch_mask=0 -> done pulse 1 cycle later, busy never asserts.
REQ-039 reset asserted in MEASURE of ch1 -> all outputs 0 immediately, no result, no done; fresh start works.
REQ-040 DUTY_SCAN_AUTORESTART_EN, mask=4'b1000 -> ch3 results repeat, done pulse after each, busy stays 1.
